// File: rtl/regfile_pkg.sv
// Shared defaults, counter opcodes and bus-slicing helper for the scoreboarded
// register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;
  localparam int CNT_MAX    = (1 << DEF_CNT_W) - 1;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_UP,
    CNT_DOWN,
    CNT_CLR
  } cnt_op_e;

  // Low bit of field idx in a packed bus of width-bit fields.
  function automatic int port_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the scoreboarded register file; master is the
// pipeline, slave is the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                     flush;
  logic [NRD-1:0]           rd_en;
  logic [NRD*ADDR_W-1:0]    rd_addr;
  logic [NRD*DATA_W-1:0]    rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     iss_valid;
  logic                     iss_we;
  logic [ADDR_W-1:0]        iss_dst;
  logic                     iss_stall;
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic [ADDR_W+CNT_W-1:0]  outstanding;
  logic                     err_wb;

  modport master (
    output flush, rd_en, rd_addr, iss_valid, iss_we, iss_dst,
           wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, iss_stall, outstanding, err_wb
  );

  modport slave (
    input  flush, rd_en, rd_addr, iss_valid, iss_we, iss_dst,
           wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, iss_stall, outstanding, err_wb
  );
endinterface

// File: rtl/regfile_sb_counter.sv
// Per-register pending-write counter: saturating up/down with synchronous
// clear; a decrement at zero is reported as underflow and does not wrap.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             underflow
);
  localparam logic [CNT_W-1:0] TOP = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  cnt_op_e          op;

  // Simultaneous inc and dec cancel, so they fall through to HOLD.
  always_comb begin
    op = CNT_HOLD;
    if (clr)
      op = CNT_CLR;
    else if (inc && !dec && cnt_reg != TOP)
      op = CNT_UP;
    else if (dec && !inc && cnt_reg != '0)
      op = CNT_DOWN;
  end

  always_comb begin
    cnt_next = cnt_reg;
    case (op)
      CNT_CLR:  cnt_next = '0;
      CNT_UP:   cnt_next = cnt_reg + ONE;
      CNT_DOWN: cnt_next = cnt_reg - ONE;
      default:  cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt       = cnt_reg;
  assign zero      = (cnt_reg == '0);
  assign full      = (cnt_reg == TOP);
  assign underflow = dec && !inc && !clr && (cnt_reg == '0);
endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: NRD combinational read ports, one write-back
// port with optional same-cycle bypass, and a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NRD     = 2,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int               NREG    = 1 << ADDR_W;
  localparam int               OUT_W   = ADDR_W + CNT_W;
  localparam bit               Z0      = (ZERO_R0 != 0);
  localparam bit               BYP     = (BYPASS != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  logic [DATA_W-1:0]     rf_q [NREG];
  logic [CNT_W-1:0]      cnt  [NREG];
  logic [NREG-1:0]       cnt_zero, cnt_full, cnt_uflow, inc_hit, dec_hit;
  logic [NRD-1:0]        busy_vec;
  logic [NRD*DATA_W-1:0] rd_data_all;
  logic                  wb_dec, iss_inc, dst_full, src_busy, stall;
  logic [OUT_W-1:0]      outstanding_reg, outstanding_next;
  logic                  err_reg;

  assign wb_dec = bus.wb_valid && !(Z0 && bus.wb_addr == '0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DATA_W-1:0] data_reg;

    assign dec_hit[gi] = wb_dec && (bus.wb_addr == ADDR_W'(gi));
    assign inc_hit[gi] = iss_inc && (bus.iss_dst == ADDR_W'(gi));

    // Register write is independent of flush: the data path never squashes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        data_reg <= '0;
      else if (dec_hit[gi])
        data_reg <= bus.wb_data;
    end
    assign rf_q[gi] = data_reg;

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_hit[gi]),
      .dec       (dec_hit[gi]),
      .clr       (bus.flush),
      .cnt       (cnt[gi]),
      .zero      (cnt_zero[gi]),
      .full      (cnt_full[gi]),
      .underflow (cnt_uflow[gi])
    );
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              is_r0, fwd, retire;

    assign addr   = bus.rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
    assign is_r0  = Z0 && (addr == '0);
    assign fwd    = BYP && bus.wb_valid && (bus.wb_addr == addr);
    assign retire = BYP && wb_dec && (bus.wb_addr == addr);

    always_comb begin
      val = rf_q[addr];
      if (fwd)
        val = bus.wb_data;
      if (is_r0)
        val = '0;
    end
    assign rd_data_all[port_lsb(gi, DATA_W) +: DATA_W] = val;

    // A lone pending write retiring this cycle is covered by the bypass.
    assign busy_vec[gi] = !is_r0 && !cnt_zero[addr] &&
                          !(retire && cnt[addr] == CNT_ONE);
  end

  assign src_busy = |(bus.rd_en & busy_vec);
  assign dst_full = bus.iss_we && cnt_full[bus.iss_dst] &&
                    !(wb_dec && bus.wb_addr == bus.iss_dst);
  assign stall    = bus.iss_valid && (src_busy || dst_full || bus.flush);
  assign iss_inc  = bus.iss_valid && bus.iss_we && !stall &&
                    !(Z0 && bus.iss_dst == '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (bus.flush) begin
      outstanding_next = '0;
    end else begin
      if (iss_inc)
        outstanding_next = outstanding_next + OUT_ONE;
      if (wb_dec && !(|cnt_uflow))
        outstanding_next = outstanding_next - OUT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (|cnt_uflow)
        err_reg <= 1'b1;
    end
  end

  assign bus.rd_data     = rd_data_all;
  assign bus.rd_busy     = busy_vec;
  assign bus.iss_stall   = stall;
  assign bus.outstanding = outstanding_reg;
  assign bus.err_wb      = err_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async-reset and r0 sequences,
// then random traffic against a counting reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2)) bus ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2)) nb ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2), .ZERO_R0(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2), .ZERO_R0(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(nb));

  assign nb.flush     = bus.flush;
  assign nb.rd_en     = bus.rd_en;
  assign nb.rd_addr   = bus.rd_addr;
  assign nb.iss_valid = bus.iss_valid;
  assign nb.iss_we    = bus.iss_we;
  assign nb.iss_dst   = bus.iss_dst;
  assign nb.wb_valid  = bus.wb_valid;
  assign nb.wb_addr   = bus.wb_addr;
  assign nb.wb_data   = bus.wb_data;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int a0, input int a1, input int en, input bit iv, input bit iw,
                       input int dst, input bit wv, input int wa, input logic [31:0] wd,
                       input bit fl);
    bus.rd_addr   = {5'(a1), 5'(a0)};
    bus.rd_en     = 2'(en);
    bus.iss_valid = iv;
    bus.iss_we    = iw;
    bus.iss_dst   = 5'(dst);
    bus.wb_valid  = wv;
    bus.wb_addr   = 5'(wa);
    bus.wb_data   = wd;
    bus.flush     = fl;
  endtask

  typedef struct {
    int a0; int a1; int en; bit iv; bit iw; int dst; bit wv; int wa; logic [31:0] wd; bit fl;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] ebusy; bit estall; int eout; bit eerr;
    bit nbchk; logic [31:0] enb1;
  } vec_t;
  vec_t tbl [26];

  // Reference model: architectural contents plus pending-write counts.
  logic [31:0] m_rf  [32];
  int          m_cnt [32];
  bit          m_err;

  function automatic int m_total();
    int s = 0;
    for (int k = 0; k < 32; k++) s += m_cnt[k];
    return s;
  endfunction

  function automatic logic [31:0] m_read(input int a, input bit wv, input int wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (wv && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic bit m_busy(input int a, input bit wv, input int wa);
    int left;
    if (a == 0) return 1'b0;
    left = m_cnt[a] - ((wv && wa != 0 && wa == a) ? 1 : 0);
    return left > 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    //          a0 a1 en iv iw dst wv wa wd            fl  e0            e1            busy st out err nb nb1
    tbl[0]  = '{0, 1, 3, 0, 0, 0,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{2, 3, 3, 1, 1, 5,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{5, 0, 1, 0, 0, 0,  1, 5, 32'hDEADBEEF, 0,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0, 0, 32'h0};
    tbl[3]  = '{5, 5, 3, 0, 0, 0,  0, 0, 32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0};
    tbl[4]  = '{0, 1, 0, 1, 1, 7,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[5]  = '{7, 7, 3, 0, 0, 0,  1, 7, 32'h1234,     0,  32'h1234,     32'h1234,     0, 0, 1, 0, 1, 32'h0};
    tbl[6]  = '{7, 7, 3, 0, 0, 0,  0, 0, 32'h0,        0,  32'h1234,     32'h1234,     0, 0, 0, 0, 1, 32'h1234};
    tbl[7]  = '{0, 1, 0, 1, 1, 3,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[8]  = '{3, 0, 1, 1, 1, 3,  0, 0, 32'h0,        0,  32'h0,        32'h0,        1, 1, 1, 0, 0, 32'h0};
    tbl[9]  = '{3, 0, 1, 1, 0, 0,  1, 3, 32'h33,       0,  32'h33,       32'h0,        0, 0, 1, 0, 0, 32'h0};
    tbl[10] = '{3, 0, 1, 0, 0, 0,  0, 0, 32'h0,        0,  32'h33,       32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{0, 1, 0, 1, 1, 9,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[12] = '{0, 1, 0, 1, 1, 9,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0};
    tbl[13] = '{0, 1, 0, 1, 1, 9,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 2, 0, 0, 32'h0};
    tbl[14] = '{0, 1, 0, 1, 1, 9,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 1, 3, 0, 0, 32'h0};
    tbl[15] = '{0, 1, 0, 1, 1, 9,  1, 9, 32'h99,       0,  32'h0,        32'h0,        0, 0, 3, 0, 0, 32'h0};
    tbl[16] = '{9, 0, 1, 0, 0, 0,  0, 0, 32'h0,        0,  32'h99,       32'h0,        1, 0, 3, 0, 0, 32'h0};
    tbl[17] = '{9, 0, 1, 0, 0, 0,  1, 9, 32'h91,       0,  32'h91,       32'h0,        1, 0, 3, 0, 0, 32'h0};
    tbl[18] = '{9, 0, 1, 0, 0, 0,  1, 9, 32'h92,       0,  32'h92,       32'h0,        1, 0, 2, 0, 0, 32'h0};
    tbl[19] = '{9, 0, 1, 0, 0, 0,  1, 9, 32'h93,       0,  32'h93,       32'h0,        0, 0, 1, 0, 0, 32'h0};
    tbl[20] = '{9, 0, 1, 0, 0, 0,  0, 0, 32'h0,        0,  32'h93,       32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[21] = '{0, 1, 0, 1, 1, 4,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[22] = '{0, 1, 0, 1, 1, 6,  0, 0, 32'h0,        0,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0};
    tbl[23] = '{4, 6, 3, 1, 1, 8,  0, 0, 32'h0,        1,  32'h0,        32'h0,        3, 1, 2, 0, 0, 32'h0};
    tbl[24] = '{4, 6, 3, 0, 0, 0,  1, 4, 32'h44,       0,  32'h44,       32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[25] = '{4, 6, 3, 0, 0, 0,  0, 0, 32'h0,        0,  32'h44,       32'h0,        0, 0, 0, 1, 0, 32'h0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].a0, tbl[i].a1, tbl[i].en, tbl[i].iv, tbl[i].iw, tbl[i].dst,
            tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].fl);
      @(negedge clk);
      check($sformatf("t%0d.rd0", i), 64'(bus.rd_data[31:0]), 64'(tbl[i].e0));
      check($sformatf("t%0d.rd1", i), 64'(bus.rd_data[63:32]), 64'(tbl[i].e1));
      check($sformatf("t%0d.busy", i), 64'(bus.rd_busy), 64'(tbl[i].ebusy));
      check($sformatf("t%0d.stall", i), 64'(bus.iss_stall), 64'(tbl[i].estall));
      check($sformatf("t%0d.outstanding", i), 64'(bus.outstanding), 64'(tbl[i].eout));
      check($sformatf("t%0d.err_wb", i), 64'(bus.err_wb), 64'(tbl[i].eerr));
      if (tbl[i].nbchk)
        check($sformatf("t%0d.nobypass_rd1", i), 64'(nb.rd_data[63:32]), 64'(tbl[i].enb1));
      @(posedge clk); #1;
    end

    // Mid-cycle asynchronous reset with two writes in flight.
    drive(0, 0, 0, 1, 1, 10, 0, 0, 32'h0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 1, 11, 0, 0, 32'h0, 0);
    @(posedge clk); #1;
    drive(5, 10, 2, 1, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check("arst.pre_outstanding", 64'(bus.outstanding), 64'd2);
    check("arst.pre_busy", 64'(bus.rd_busy), 64'd2);
    check("arst.pre_stall", 64'(bus.iss_stall), 64'd1);
    check("arst.pre_err", 64'(bus.err_wb), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.outstanding", 64'(bus.outstanding), 64'd0);
    check("arst.err_wb", 64'(bus.err_wb), 64'd0);
    check("arst.rd0", 64'(bus.rd_data[31:0]), 64'd0);
    check("arst.busy", 64'(bus.rd_busy), 64'd0);
    check("arst.stall", 64'(bus.iss_stall), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    @(posedge clk); #1;

    // r0 never becomes busy, ignores writes and never underflows.
    drive(0, 0, 3, 1, 1, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check("r0.iss_stall", 64'(bus.iss_stall), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 3, 0, 0, 0, 1, 0, 32'hFF, 0);
    @(negedge clk);
    check("r0.outstanding", 64'(bus.outstanding), 64'd0);
    check("r0.bypass_rd0", 64'(bus.rd_data[31:0]), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check("r0.rd0", 64'(bus.rd_data[31:0]), 64'd0);
    check("r0.err_wb", 64'(bus.err_wb), 64'd0);
    @(posedge clk); #1;

    // Random traffic against the model; state is all zero at this point.
    for (int k = 0; k < 32; k++) begin
      m_rf[k]  = 32'h0;
      m_cnt[k] = 0;
    end
    m_err = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int a0, a1, en, dst, wa, npend;
      int pend [$];
      bit iv, iw, wv, fl, stall, busy0, busy1, accept;
      logic [31:0] wd;
      a0  = $urandom_range(0, 7);
      a1  = $urandom_range(0, 7);
      en  = $urandom_range(0, 3);
      iv  = ($urandom_range(0, 9) < 6);
      iw  = ($urandom_range(0, 9) < 8);
      dst = $urandom_range(0, 7);
      wv  = $urandom_range(0, 1);
      fl  = ($urandom_range(0, 39) == 0);
      wd  = $urandom;
      pend.delete();
      for (int k = 1; k < 8; k++) if (m_cnt[k] > 0) pend.push_back(k);
      npend = pend.size();
      if (npend > 0 && $urandom_range(0, 9) != 0)
        wa = pend[$urandom_range(0, npend - 1)];
      else
        wa = $urandom_range(0, 7);
      drive(a0, a1, en, iv, iw, dst, wv, wa, wd, fl);
      @(negedge clk);
      busy0 = m_busy(a0, wv, wa);
      busy1 = m_busy(a1, wv, wa);
      stall = iv && (((en & 1) != 0 && busy0) || ((en & 2) != 0 && busy1) ||
                     (iw && m_cnt[dst] == CNT_MAX && !(wv && wa != 0 && wa == dst)) || fl);
      check($sformatf("r%0d.rd0", c), 64'(bus.rd_data[31:0]), 64'(m_read(a0, wv, wa, wd)));
      check($sformatf("r%0d.rd1", c), 64'(bus.rd_data[63:32]), 64'(m_read(a1, wv, wa, wd)));
      check($sformatf("r%0d.busy", c), 64'(bus.rd_busy), 64'({busy1, busy0}));
      check($sformatf("r%0d.stall", c), 64'(bus.iss_stall), 64'(stall));
      check($sformatf("r%0d.outstanding", c), 64'(bus.outstanding), 64'(m_total()));
      check($sformatf("r%0d.err_wb", c), 64'(bus.err_wb), 64'(m_err));
      accept = iv && iw && !stall && dst != 0;
      if (fl) begin
        for (int k = 0; k < 32; k++) m_cnt[k] = 0;
      end else begin
        if (accept) m_cnt[dst]++;
        if (wv && wa != 0) begin
          if (m_cnt[wa] > 0) m_cnt[wa]--;
          else m_err = 1'b1;
        end
      end
      if (wv && wa != 0) m_rf[wa] = wd;
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised decode-stage register file with N read ports, one write-back port, write-through bypass, and a per-register pending-write scoreboard.
- Replaces the fixed 2-read regfile plus stall-mux arrangement in decode.
- Decode uses rd_busy / iss_stall to hold instructions whose sources or destination are still in flight.
- Write-back drives the write port directly.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; NREG = 2**ADDR_W.
- NRD, 2: number of read ports (1..4).
- CNT_W, 2: per-register pending-write counter width; max in-flight writes per register = 2**CNT_W-1.
- ZERO_R0, 1: 1 = register 0 reads 0, ignores writes, and never becomes busy.
- BYPASS, 1: 1 = same-cycle write-back data is forwarded to read ports.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; clears all scoreboard counters (in-flight writes are squashed)
- rd_en  in  NRD  per-port read valid (used only for stall evaluation)
- rd_addr  in  NRD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  packed read data, combinational
- rd_busy  out  NRD  port i source has an outstanding write not satisfied this cycle
- iss_valid  in  1  decode attempts to issue an instruction this cycle
- iss_we  in  1  the issuing instruction writes a register
- iss_dst  in  ADDR_W  destination of the issuing instruction
- iss_stall  out  1  issue blocked this cycle; the scoreboard is not updated
- wb_valid  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data
- outstanding  out  ADDR_W+CNT_W  total pending writes across all registers
- err_wb  out  1  sticky: write-back to a register whose counter was 0 (flush excepted)

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, all counters, outstanding and err_wb go to 0.
  - rd_data then reads 0; rd_busy and iss_stall are 0.
- Write:
  - On posedge, if wb_valid and not (ZERO_R0 and wb_addr==0), rf[wb_addr] <= wb_data.
  - The write is not affected by flush.
- Read: rd_data[i] is selected in priority order:
  - 0 if ZERO_R0 and addr==0;
  - else wb_data if BYPASS and wb_valid and wb_addr==addr;
  - else rf[addr].
- wb_dec: wb_valid and wb_addr not excluded by ZERO_R0.
- rd_busy[i]:
  - Equals cnt[addr] > (wb_dec and wb_addr==addr and BYPASS ? 1 : 0).
  - A register with a single pending write, retiring this cycle, is not busy because the bypass supplies the data.
  - Always 0 for r0 when ZERO_R0.
- iss_stall, asserted when iss_valid and any of:
  - (rd_en[i] and rd_busy[i]) for any i;
  - iss_we and cnt[iss_dst] at max and not (wb_dec and wb_addr==iss_dst);
  - flush is high (no issue during a flush).
- iss_inc: iss_valid and iss_we and not iss_stall and dst not r0 under ZERO_R0.
- Counter update on posedge:
  - If flush: all cnt <= 0 and outstanding <= 0, overriding any same-cycle issue or write-back.
  - Otherwise, per register: cnt += iss_inc(hit) - wb_dec(hit).
  - Issue and write-back to the same register in the same cycle leaves cnt unchanged.
  - outstanding += iss_inc - wb_dec with the same rule.
- Write-back underflow:
  - Condition: wb_dec hits a register with cnt==0 while flush is low.
  - cnt stays 0 (no wrap), outstanding does not decrement, err_wb <= 1.
  - err_wb holds until reset.
  - Write-backs from squashed instructions after a flush are a caller error and are flagged this way.
- Timing: latency 0 for reads, bypass and stall; 1 cycle for writes and counter updates.
- r0 with ZERO_R0=0: behaves as an ordinary register.

Decomposition:
- Shared package regfile_pkg:
  - defaults DATA_W, ADDR_W, CNT_W;
  - function to unpack port i from a packed bus;
  - localparam CNT_MAX.
- One sub-module, sb_counter: a CNT_W saturating up/down counter with inc, dec, clr inputs and zero/full/underflow outputs, instantiated NREG times.
- Read muxing and stall logic are inline.

Test Plan:
1. Reset then read all ports at addresses 0..3 -> rd_data=0, rd_busy=0, outstanding=0. Write r5=0xDEADBEEF, then read r5 next cycle -> 0xDEADBEEF.
2. Bypass: wb_valid, wb_addr=7, wb_data=0x1234, rd_addr[1]=7 in the same cycle -> rd_data[1]=0x1234 that cycle. Check against BYPASS=0 -> old value.
3. Scoreboard:
   - Issue iss_dst=3; next cycle rd_en[0], rd_addr[0]=3, iss_valid -> rd_busy[0]=1, iss_stall=1, counter unchanged.
   - wb to r3 that cycle -> rd_busy[0]=0 and iss_stall=0.
4. Saturation with CNT_W=2: issue dst=9 three times -> outstanding=3; a fourth issue -> iss_stall=1. A fourth issue concurrent with wb to r9 -> accepted, cnt stays 3.
5. Flush:
   - Issue dst=4 and dst=6, then flush -> next cycle outstanding=0, rd_busy=0.
   - wb to r4 afterwards -> rf[4] written, err_wb=1, outstanding stays 0.
6. r0 and async reset: issue dst=0 -> outstanding unchanged; wb r0=0xFF -> reads 0. Pull rst_n low mid-cycle with outstanding=2 -> immediate clear of outputs and err_wb.
